// File: rtl/axi4_stream_byte_packer_pkg.sv
// Shared AXI4-Stream helpers: byte-lane width constants and a lane popcount.
package axi4_stream_byte_packer_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int MAX_LANES      = 64;
  localparam int LANE_CNT_WIDTH = 8;

  function automatic logic [LANE_CNT_WIDTH-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [LANE_CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {{(LANE_CNT_WIDTH-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Plain AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
) ();

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);

endinterface

// File: rtl/axi4_stream_tkeep_compact.sv
// Moves kept bytes of one word down to consecutive low lanes, preserving order.
module axi4_stream_tkeep_compact
  import axi4_stream_byte_packer_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  localparam int W  = TDATA_WIDTH / BYTE_WIDTH,
  localparam int NW = $clog2(W) + 1
) (
  input  logic [TDATA_WIDTH-1:0] tdata,
  input  logic [W-1:0]           tstrb,
  input  logic [W-1:0]           tkeep,
  output logic [TDATA_WIDTH-1:0] data,
  output logic [W-1:0]           strb,
  output logic [NW-1:0]          n
);

  logic [NW-1:0]        prefix [W];
  logic [NW-1:0]        acc;
  logic [MAX_LANES-1:0] keep_ext;

  // prefix[i] is the destination lane of input byte i when that byte is kept
  always_comb begin
    acc = '0;
    for (int i = 0; i < W; i++) begin
      prefix[i] = acc;
      acc       = acc + NW'(tkeep[i]);
    end
  end

  always_comb begin
    data = '0;
    strb = '0;
    for (int j = 0; j < W; j++) begin
      for (int i = j; i < W; i++) begin
        if (tkeep[i] && prefix[i] == NW'(j)) begin
          data[j*BYTE_WIDTH +: BYTE_WIDTH] = tdata[i*BYTE_WIDTH +: BYTE_WIDTH];
          strb[j]                          = tstrb[i];
        end
      end
    end
  end

  always_comb begin
    keep_ext        = '0;
    keep_ext[W-1:0] = tkeep;
    n               = NW'(popcount(keep_ext));
  end

endmodule

// File: rtl/axi4_stream_byte_packer.sv
// Strips null bytes from an AXI4-Stream and repacks the rest into full words;
// only the final word of a packet may be partial, with contiguous low tkeep.
module axi4_stream_byte_packer
  import axi4_stream_byte_packer_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);

  localparam int W     = TDATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 * W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int NW    = $clog2(W) + 1;

  logic [CW-1:0]          cnt, cnt_next;
  logic                   eop_pend, was_eop;
  logic [BYTE_WIDTH-1:0]  buf_data [DEPTH];
  logic                   buf_strb [DEPTH];
  logic [BYTE_WIDTH-1:0]  nxt_data [DEPTH];
  logic                   nxt_strb [DEPTH];
  logic [TID_WIDTH-1:0]   tid_q;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic [TUSER_WIDTH-1:0] tuser_q;

  logic [TDATA_WIDTH-1:0] comp_data;
  logic [W-1:0]           comp_strb;
  logic [NW-1:0]          comp_n;

  logic          tx_full, tx_last, tx_fire, rx_ready, rx_fire;
  logic [CW-1:0] tx_avail, tx_bytes, base, src, dst;

  axi4_stream_tkeep_compact #(.TDATA_WIDTH(TDATA_WIDTH)) u_compact (
    .tdata (pkt_i.tdata),
    .tstrb (pkt_i.tstrb),
    .tkeep (pkt_i.tkeep),
    .data  (comp_data),
    .strb  (comp_strb),
    .n     (comp_n)
  );

  // One byte is always held back until tlast arrives, so a word is only
  // released early when more than a full word is buffered.
  always_comb begin
    tx_full  = cnt > CW'(W);
    tx_last  = eop_pend && cnt != '0 && cnt <= CW'(W);
    tx_avail = tx_full ? CW'(W) : (tx_last ? cnt : '0);
    tx_fire  = (tx_full || tx_last) && pkt_o.tready;
    tx_bytes = tx_fire ? tx_avail : '0;
    rx_ready = !eop_pend && (cnt <= CW'(W) || pkt_o.tready);
    rx_fire  = pkt_i.tvalid && rx_ready;
    cnt_next = cnt - tx_bytes + (rx_fire ? CW'(comp_n) : CW'(0));
  end

  assign pkt_i.tready = rx_ready;

  always_comb begin
    pkt_o.tvalid = tx_full || tx_last;
    pkt_o.tlast  = tx_last;
    pkt_o.tdata  = '0;
    pkt_o.tstrb  = '0;
    pkt_o.tkeep  = '0;
    for (int i = 0; i < W; i++) begin
      if (CW'(i) < tx_avail) begin
        pkt_o.tdata[i*BYTE_WIDTH +: BYTE_WIDTH] = buf_data[i];
        pkt_o.tstrb[i]                          = buf_strb[i];
        pkt_o.tkeep[i]                          = 1'b1;
      end
    end
    pkt_o.tid   = tid_q;
    pkt_o.tdest = tdest_q;
    pkt_o.tuser = tuser_q;
  end

  // Shift out departing bytes, then append the compacted word behind what stays.
  always_comb begin
    src  = '0;
    dst  = '0;
    base = cnt - tx_bytes;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_data[i] = '0;
      nxt_strb[i] = 1'b0;
      src = CW'(i) + tx_bytes;
      if (src < CW'(DEPTH)) begin
        nxt_data[i] = buf_data[src[AW-1:0]];
        nxt_strb[i] = buf_strb[src[AW-1:0]];
      end
    end
    for (int k = 0; k < W; k++) begin
      dst = base + CW'(k);
      if (rx_fire && CW'(k) < CW'(comp_n) && dst < CW'(DEPTH)) begin
        nxt_data[dst[AW-1:0]] = comp_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        nxt_strb[dst[AW-1:0]] = comp_strb[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      eop_pend <= 1'b0;
      was_eop  <= 1'b1;
      tid_q    <= '0;
      tdest_q  <= '0;
      tuser_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_strb[i] <= 1'b0;
      end
    end else begin
      cnt <= cnt_next;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= nxt_data[i];
        buf_strb[i] <= nxt_strb[i];
      end
      if (rx_fire) begin
        was_eop <= pkt_i.tlast;
      end
      if (rx_fire && was_eop) begin
        tid_q   <= pkt_i.tid;
        tdest_q <= pkt_i.tdest;
        tuser_q <= pkt_i.tuser;
      end
      // A zero-byte packet leaves cnt at 0 and never raises eop_pend.
      if (rx_fire && pkt_i.tlast) begin
        eop_pend <= (cnt_next != '0);
      end else if (tx_fire && tx_last) begin
        eop_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_stream_byte_packer.sv
// Randomised bench for the byte packer against a byte-queue reference model.
module tb_axi4_stream_byte_packer;

  localparam int W = 8;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
  } exp_word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(64), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(64), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) out_if ();

  axi4_stream_byte_packer #(
    .TDATA_WIDTH(64), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pkt_i (in_if),
    .pkt_o (out_if)
  );

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  exp_word_t   exp_q [$];
  logic [63:0] obs_data [$];
  int          obs_cycle [$];
  int          occ = 0;
  bit          eop = 1'b0;

  bit force_low  = 1'b0;
  bit rand_ready = 1'b0;
  int hold_low   = 0;

  logic [63:0] pkt_data [$];
  logic [7:0]  pkt_keep [$];

  exp_word_t   mon_e;
  logic [63:0] mon_mask;
  bit          mon_in_fire, mon_out_fire, mon_valid, mon_ready;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Output-side ready driver: forced low, a short low window, random, or steady high.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_low) out_if.tready = 1'b0;
      else if (hold_low > 0) begin
        out_if.tready = 1'b0;
        hold_low--;
      end else if (rand_ready) out_if.tready = ($urandom_range(0, 3) != 0);
      else out_if.tready = 1'b1;
    end
  end

  // Reference model: occupancy and pending end-of-packet follow the byte counts,
  // and every output handshake must match the next precomputed expected word.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst) begin
        mon_valid = (occ > W) || (eop && occ > 0);
        mon_ready = !eop && (occ <= W || out_if.tready);
        checkOutput("out_tvalid", 64'(out_if.tvalid), 64'(mon_valid));
        checkOutput("in_tready", 64'(in_if.tready), 64'(mon_ready));
        mon_in_fire  = in_if.tvalid && in_if.tready;
        mon_out_fire = out_if.tvalid && out_if.tready;
        if (mon_out_fire) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", 64'(out_if.tkeep), 64'h0);
          end else begin
            mon_e = exp_q.pop_front();
            mon_mask = '0;
            for (int b = 0; b < W; b++) if (mon_e.keep[b]) mon_mask[b*8 +: 8] = 8'hFF;
            checkOutput("tdata", out_if.tdata & mon_mask, mon_e.data);
            checkOutput("tkeep", 64'(out_if.tkeep), 64'(mon_e.keep));
            checkOutput("tstrb", 64'(out_if.tstrb), 64'(mon_e.strb));
            checkOutput("tlast", 64'(out_if.tlast), 64'(mon_e.last));
            checkOutput("tid", 64'(out_if.tid), 64'(mon_e.id));
            checkOutput("tdest", 64'(out_if.tdest), 64'(mon_e.dest));
            checkOutput("tuser", 64'(out_if.tuser), 64'(mon_e.user));
            occ -= $countones(mon_e.keep);
            if (mon_e.last) eop = 1'b0;
            obs_data.push_back(out_if.tdata);
            obs_cycle.push_back(cycle);
          end
        end
        if (mon_in_fire) begin
          occ += $countones(in_if.tkeep);
          if (in_if.tlast && occ > 0) eop = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendWord(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                          input logic l, input logic id, input logic dest, input logic user);
    int budget;
    bit done;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tstrb  = s;
    in_if.tlast  = l;
    in_if.tid    = id;
    in_if.tdest  = dest;
    in_if.tuser  = user;
    budget = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_if.tready) done = 1'b1;
      else begin
        budget++;
        if (budget > 300) begin
          checkOutput("send_timeout", 64'(budget), 64'h0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  // Sends the packet held in pkt_data/pkt_keep and queues the words it should become.
  task automatic applyStimulus(input logic id, input logic dest, input logic user, input int hold_at);
    logic [7:0] bd [$];
    logic       bs [$];
    logic [7:0] strb_w [$];
    exp_word_t  e;
    int         n;
    for (int w = 0; w < pkt_data.size(); w++) begin
      strb_w.push_back(8'($urandom_range(0, 255)) & pkt_keep[w]);
      for (int b = 0; b < W; b++) begin
        if (pkt_keep[w][b]) begin
          bd.push_back(pkt_data[w][b*8 +: 8]);
          bs.push_back(strb_w[w][b]);
        end
      end
    end
    while (bd.size() > 0) begin
      e = '{data: 64'h0, strb: 8'h0, keep: 8'h0, last: 1'b0, id: id, dest: dest, user: user};
      n = (bd.size() > W) ? W : bd.size();
      for (int j = 0; j < n; j++) begin
        e.data[j*8 +: 8] = bd.pop_front();
        e.strb[j]        = bs.pop_front();
        e.keep[j]        = 1'b1;
      end
      e.last = (bd.size() == 0);
      exp_q.push_back(e);
    end
    for (int w = 0; w < pkt_data.size(); w++) begin
      if (w == hold_at) hold_low = 5;
      sendWord(pkt_data[w], pkt_keep[w], strb_w[w], (w == pkt_data.size() - 1), id, dest, user);
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || occ != 0) && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 500) checkOutput("drain_timeout", 64'(exp_q.size()), 64'h0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tstrb  = '0;
    in_if.tlast  = 1'b0;
    in_if.tid    = 1'b0;
    in_if.tdest  = 1'b0;
    in_if.tuser  = 1'b0;

    #1;
    checkOutput("rst_tvalid", 64'(out_if.tvalid), 64'h0);
    checkOutput("rst_tlast", 64'(out_if.tlast), 64'h0);
    checkOutput("rst_tkeep", 64'(out_if.tkeep), 64'h0);
    checkOutput("rst_tstrb", 64'(out_if.tstrb), 64'h0);
    checkOutput("rst_tdata", out_if.tdata, 64'h0);
    checkOutput("rst_tid", 64'(out_if.tid), 64'h0);
    checkOutput("rst_tdest", 64'(out_if.tdest), 64'h0);
    checkOutput("rst_tuser", 64'(out_if.tuser), 64'h0);
    checkOutput("rst_in_tready", 64'(in_if.tready), 64'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] full words then a 4-byte tail");
    base = obs_data.size();
    pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    pkt_keep = '{8'hFF, 8'hFF, 8'h0F};
    applyStimulus(1'b1, 1'b0, 1'b1, -1);
    waitDrain();
    checkOutput("t1_word_count", 64'(obs_data.size() - base), 64'd3);
    if (obs_data.size() - base == 3)
      checkOutput("t1_back_to_back", 64'(obs_cycle[base+2] - obs_cycle[base+1]), 64'd1);

    $display("[TB] alternating tkeep 55");
    base = obs_data.size();
    pkt_data = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110, 64'h1F1E1D1C1B1A1918};
    pkt_keep = '{8'h55, 8'h55, 8'h55, 8'h55};
    applyStimulus(1'b0, 1'b1, 1'b0, -1);
    waitDrain();
    checkOutput("t2_word_count", 64'(obs_data.size() - base), 64'd2);
    if (obs_data.size() - base == 2) begin
      checkOutput("t2_word0", obs_data[base], 64'h0E0C0A0806040200);
      checkOutput("t2_word1", obs_data[base+1], 64'h1E1C1A1816141210);
    end

    $display("[TB] empty tlast word flushes held bytes");
    base = obs_data.size();
    pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}};
    pkt_keep = '{8'hFF, 8'h00};
    applyStimulus(1'b1, 1'b1, 1'b0, -1);
    waitDrain();
    checkOutput("t3_word_count", 64'(obs_data.size() - base), 64'd1);

    $display("[TB] zero-byte packet is dropped");
    base = obs_data.size();
    pkt_data = '{{$urandom, $urandom}};
    pkt_keep = '{8'h00};
    applyStimulus(1'b0, 1'b1, 1'b1, -1);
    waitDrain();
    checkOutput("t4_no_output", 64'(obs_data.size() - base), 64'd0);
    pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}};
    pkt_keep = '{8'hF3, 8'h3C};
    applyStimulus(1'b1, 1'b0, 1'b0, -1);
    waitDrain();

    $display("[TB] random tkeep packets with backpressure");
    rand_ready = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int nw;
      nw = $urandom_range(1, 6);
      pkt_data.delete();
      pkt_keep.delete();
      for (int w = 0; w < nw; w++) begin
        pkt_data.push_back({$urandom, $urandom});
        pkt_keep.push_back(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
      end
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (p % 5 == 2) ? nw / 2 : -1);
    end
    waitDrain();
    rand_ready = 1'b0;

    $display("[TB] reset mid-packet");
    force_low = 1'b1;
    @(posedge clk);
    #1;
    sendWord({$urandom, $urandom}, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    sendWord({$urandom, $urandom}, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pre_reset_tvalid", 64'(out_if.tvalid), 64'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    occ = 0;
    eop = 1'b0;
    #1;
    checkOutput("async_rst_tvalid", 64'(out_if.tvalid), 64'h0);
    checkOutput("async_rst_tkeep", 64'(out_if.tkeep), 64'h0);
    checkOutput("async_rst_in_tready", 64'(in_if.tready), 64'h1);
    checkOutput("async_rst_cnt", 64'(dut.cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_low = 1'b0;
    base = obs_data.size();
    pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}};
    pkt_keep = '{8'hFF, 8'hE1};
    applyStimulus(1'b1, 1'b1, 1'b1, -1);
    waitDrain();
    checkOutput("t6_word_count", 64'(obs_data.size() - base), 64'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
